// File: rtl/spi_master_cfg_if.sv
// Local handshake plus SPI pins for spi_master_cfg.
// Latency: n/a (bundle only). Backpressure: none, START is only honoured while BUSY=0.
// master = the SPI master block, slave = local requester together with the SPI bus side.
interface spi_master_cfg_if #(
    parameter int WIDTH = 8,
    parameter int N_CS  = 1,
    parameter int CS_W  = 1
) ();
    logic             start;
    logic             cpol;
    logic             cpha;
    logic             lsb_first;
    logic [CS_W-1:0]  cs_idx;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic             sck;
    logic             mosi;
    logic             miso;
    logic [N_CS-1:0]  cs_n;

    modport master (
        input  start, cpol, cpha, lsb_first, cs_idx, dout, miso,
        output din, busy, done, sck, mosi, cs_n
    );

    modport slave (
        output start, cpol, cpha, lsb_first, cs_idx, dout, miso,
        input  din, busy, done, sck, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: any CPOL/CPHA, MSB/LSB first, N active-low chip selects.
// Latency: BUSY high for CLK_DIV*(2*WIDTH+3) cycles, DONE and DIN in the first GAP cycle.
// Backpressure: none; START is ignored unless the FSM is IDLE.
module spi_master_cfg #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4,
    parameter int N_CS    = 1,
    parameter int CS_W    = (N_CS > 1) ? $clog2(N_CS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_cfg_if.master bus
);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * WIDTH + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [EDGE_W-1:0] edge_cnt, edge_cnt_nxt;
    logic             cpol_q, cpol_nxt, cpha_q, cpha_nxt, lsb_q, lsb_nxt;
    logic [WIDTH-1:0] tx_sr, tx_sr_nxt, rx_sr, rx_sr_nxt, din_q, din_nxt;
    logic             sck_q, sck_nxt, mosi_q, mosi_nxt;
    logic             busy_q, busy_nxt, done_q, done_nxt;
    logic [N_CS-1:0]  cs_n_q, cs_n_nxt, cs_sel;
    logic             div_end, sck_edge, leading, last_edge, do_sample, do_drive;

    assign div_end   = (div_cnt == DIV_LAST);
    assign sck_edge  = (state == S_SHIFT) && div_end;
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == EDGE_LAST);
    // CPHA=0 samples on leading edges and drives on trailing ones; CPHA=1 the reverse.
    assign do_sample = sck_edge && (cpha_q ? ~leading : leading);
    assign do_drive  = sck_edge && (cpha_q ? leading : (~leading && ~last_edge));

    // Out-of-range CS_IDX leaves every line deasserted.
    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < N_CS; i++) begin
            if (int'(bus.cs_idx) == i) cs_sel[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start)            state_nxt = S_LEAD;
            S_LEAD:  if (div_end)              state_nxt = S_SHIFT;
            S_SHIFT: if (sck_edge && last_edge) state_nxt = S_TRAIL;
            S_TRAIL: if (div_end)              state_nxt = S_GAP;
            S_GAP:   if (div_end)              state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        div_cnt_nxt  = (state == S_IDLE || div_end) ? '0 : div_cnt + DIV_W'(1);
        edge_cnt_nxt = (state == S_IDLE) ? '0 : (sck_edge ? edge_cnt + EDGE_W'(1) : edge_cnt);
        cpol_nxt  = cpol_q;
        cpha_nxt  = cpha_q;
        lsb_nxt   = lsb_q;
        tx_sr_nxt = tx_sr;
        rx_sr_nxt = rx_sr;
        din_nxt   = din_q;
        sck_nxt   = sck_q;
        mosi_nxt  = mosi_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        cs_n_nxt  = cs_n_q;
        case (state)
            S_IDLE: begin
                sck_nxt  = bus.cpol;
                mosi_nxt = 1'b0;
                busy_nxt = 1'b0;
                cs_n_nxt = '1;
                if (bus.start) begin
                    cpol_nxt  = bus.cpol;
                    cpha_nxt  = bus.cpha;
                    lsb_nxt   = bus.lsb_first;
                    busy_nxt  = 1'b1;
                    cs_n_nxt  = cs_sel;
                    rx_sr_nxt = '0;
                    if (bus.cpha) begin
                        tx_sr_nxt = bus.dout;
                    end else begin
                        mosi_nxt  = bus.lsb_first ? bus.dout[0] : bus.dout[WIDTH-1];
                        tx_sr_nxt = bus.lsb_first ? (bus.dout >> 1) : (bus.dout << 1);
                    end
                end
            end
            S_LEAD: sck_nxt = cpol_q;
            S_SHIFT: begin
                if (sck_edge) sck_nxt = ~sck_q;
                if (do_drive) begin
                    mosi_nxt  = lsb_q ? tx_sr[0] : tx_sr[WIDTH-1];
                    tx_sr_nxt = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
                end
                if (do_sample) begin
                    rx_sr_nxt = lsb_q ? {bus.miso, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], bus.miso};
                end
            end
            S_TRAIL: begin
                sck_nxt = cpol_q;
                if (div_end) begin
                    cs_n_nxt = '1;
                    done_nxt = 1'b1;
                    din_nxt  = rx_sr;
                    mosi_nxt = 1'b0;
                end
            end
            S_GAP: begin
                sck_nxt = cpol_q;
                if (div_end) busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            din_q    <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= '1;
        end else begin
            div_cnt  <= div_cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            cpol_q   <= cpol_nxt;
            cpha_q   <= cpha_nxt;
            lsb_q    <= lsb_nxt;
            tx_sr    <= tx_sr_nxt;
            rx_sr    <= rx_sr_nxt;
            din_q    <= din_nxt;
            sck_q    <= sck_nxt;
            mosi_q   <= mosi_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            cs_n_q   <= cs_n_nxt;
        end
    end

    assign bus.din  = din_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sck  = sck_q;
    assign bus.mosi = mosi_q;
    assign bus.cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: CLK_DIV=4/N_CS=4 instance with loopback or slave model,
// plus a CLK_DIV=1 loopback instance.
module tb_spi_master_cfg;
    localparam int L0 = 4 * (2 * 8 + 3);
    localparam int L1 = 1 * (2 * 8 + 3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    spi_master_cfg_if #(.WIDTH(8), .N_CS(4), .CS_W(2)) bus0 ();
    spi_master_cfg_if #(.WIDTH(8), .N_CS(1), .CS_W(1)) bus1 ();

    spi_master_cfg #(.WIDTH(8), .CLK_DIV(4), .N_CS(4), .CS_W(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_master_cfg #(.WIDTH(8), .CLK_DIV(1), .N_CS(1), .CS_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic       loop_en = 1'b1;
    logic       slv_miso = 1'b0;
    logic [7:0] slv_reply = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic       slv_cs_prev = 1'b1, slv_sck_prev = 1'b0;
    int         slv_idx = 0;

    assign bus0.miso = loop_en ? bus0.mosi : slv_miso;
    assign bus1.miso = bus1.mosi;

    function automatic logic slv_bit(input int i);
        if (i > 7) return 1'b0;
        return s_lsb ? slv_reply[i] : slv_reply[7-i];
    endfunction

    // Slave on CS_N[0]: CPHA=0 presents its first bit at CS fall.
    always @(bus0.sck or bus0.cs_n[0]) begin
        if (bus0.cs_n[0] === 1'b0 && slv_cs_prev === 1'b1) begin
            slv_idx  = 0;
            slv_rx   = 8'h00;
            slv_miso = s_cpha ? 1'b0 : slv_bit(0);
        end else if (bus0.cs_n[0] === 1'b0 && bus0.sck !== slv_sck_prev) begin
            if ((bus0.sck != s_cpol) != s_cpha) begin
                slv_rx = s_lsb ? {bus0.mosi, slv_rx[7:1]} : {slv_rx[6:0], bus0.mosi};
            end else if (s_cpha) begin
                slv_miso = slv_bit(slv_idx);
                slv_idx++;
            end else begin
                slv_idx++;
                slv_miso = slv_bit(slv_idx);
            end
        end
        slv_cs_prev  = bus0.cs_n[0];
        slv_sck_prev = bus0.sck;
    end

    int   busy_tot = 0, done_tot = 0, sck_tot = 0, cslo_tot = 0, cshi_tot = 0;
    int   hi_run = 0, last_hi_run = 0;
    int   busy1_tot = 0, done1_tot = 0, sck1_tot = 0;
    logic sck_prev = 1'b0, sck1_prev = 1'b0;

    always @(negedge clk) begin
        if (bus0.busy === 1'b1) busy_tot++;
        if (bus0.done === 1'b1) done_tot++;
        if (bus0.sck !== sck_prev) sck_tot++;
        sck_prev = bus0.sck;
        if (bus0.busy === 1'b1 && bus0.cs_n[0] === 1'b0) cslo_tot++;
        if (bus0.busy === 1'b1 && bus0.cs_n[0] === 1'b1) cshi_tot++;
        if (bus0.cs_n[0] === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
        if (bus1.busy === 1'b1) busy1_tot++;
        if (bus1.done === 1'b1) done1_tot++;
        if (bus1.sck !== sck1_prev) sck1_tot++;
        sck1_prev = bus1.sck;
    end

    int         res_busy, res_done, res_sck, res_cslo, res_cshi, res_gap;
    logic       res_mosi0, res_sck_before, res_sck_after;
    logic [3:0] res_cs0;

    task automatic run_xfer(input logic [7:0] d, input logic pol, input logic pha, input logic lsb,
                            input logic [1:0] idx, input int pre, input bit pulse);
        int k, b0, d0, e0, l0, h0;
        k = 0;
        while (bus0.busy !== 1'b0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        bus0.dout = d; bus0.cpol = pol; bus0.cpha = pha; bus0.lsb_first = lsb; bus0.cs_idx = idx;
        s_cpol = pol; s_cpha = pha;
        repeat (pre) begin
            @(posedge clk); #1;
        end
        res_sck_before = bus0.sck;
        b0 = busy_tot; d0 = done_tot; e0 = sck_tot; l0 = cslo_tot; h0 = cshi_tot;
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        res_mosi0 = bus0.mosi;
        res_cs0   = bus0.cs_n;
        k = 1;
        while (bus0.busy !== 1'b0 && k <= 400) begin
            bus0.start = pulse && (k == 10 || k == 40 || k == L0);
            @(posedge clk); #1;
            k++;
        end
        bus0.start = 1'b0;
        checks++;
        if (k > 400) begin
            errors++;
            $display("FAIL xfer_timeout busy=%b after %0d cycles", bus0.busy, k);
        end
        res_busy = busy_tot - b0; res_done = done_tot - d0; res_sck = sck_tot - e0;
        res_cslo = cslo_tot - l0; res_cshi = cshi_tot - h0; res_gap = last_hi_run;
        res_sck_after = bus0.sck;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.cpol = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus0.sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", bus0.sck); end
        checks++; if (bus0.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", bus0.mosi); end
        checks++; if (bus0.cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n got %b want 1111", bus0.cs_n); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus0.done); end
        checks++; if (bus0.din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", bus0.din); end
        bus0.cpol = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mode0_loopback();
        loop_en = 1'b1;
        run_xfer(8'h56, 1'b0, 1'b0, 1'b0, 2'd0, 2, 1'b0);
        checks++; if (res_busy != 76) begin errors++; $display("FAIL m0_busy_len got %0d want 76", res_busy); end
        checks++; if (res_sck != 16) begin errors++; $display("FAIL m0_sck_edges got %0d want 16", res_sck); end
        checks++; if (bus0.din !== 8'h56) begin errors++; $display("FAIL m0_din got %h want 56", bus0.din); end
        checks++; if (res_done != 1) begin errors++; $display("FAIL m0_done got %0d want 1", res_done); end
        checks++; if (res_cslo != 72) begin errors++; $display("FAIL m0_cs_low got %0d want 72", res_cslo); end
        checks++; if (res_cshi != 4) begin errors++; $display("FAIL m0_cs_gap got %0d want 4", res_cshi); end
        checks++; if (res_sck_after !== 1'b0) begin errors++; $display("FAIL m0_sck_idle got %b want 0", res_sck_after); end
    endtask

    task automatic test_modes();
        loop_en = 1'b0;
        slv_reply = 8'h34;
        s_lsb = 1'b0;
        for (int m = 0; m < 4; m++) begin
            logic [1:0] mb;
            mb = 2'(m);
            run_xfer(8'h56, mb[1], mb[0], 1'b0, 2'd0, 2, 1'b0);
            checks++; if (bus0.din !== 8'h34) begin errors++; $display("FAIL mode%0d_din got %h want 34", m, bus0.din); end
            checks++; if (slv_rx !== 8'h56) begin errors++; $display("FAIL mode%0d_slave_rx got %h want 56", m, slv_rx); end
            checks++; if (res_sck_before !== mb[1]) begin errors++; $display("FAIL mode%0d_sck_before got %b want %b", m, res_sck_before, mb[1]); end
            checks++; if (res_sck_after !== mb[1]) begin errors++; $display("FAIL mode%0d_sck_after got %b want %b", m, res_sck_after, mb[1]); end
        end
    endtask

    task automatic test_lsb_first();
        loop_en = 1'b1;
        run_xfer(8'h01, 1'b0, 1'b0, 1'b1, 2'd0, 2, 1'b0);
        checks++; if (res_mosi0 !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b want 1", res_mosi0); end
        checks++; if (bus0.din !== 8'h01) begin errors++; $display("FAIL lsb_loop_din got %h want 01", bus0.din); end
        loop_en = 1'b0;
        slv_reply = 8'h80;
        s_lsb = 1'b0;
        run_xfer(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 2, 1'b0);
        checks++; if (bus0.din !== 8'h01) begin errors++; $display("FAIL lsb_slave_din got %h want 01", bus0.din); end
    endtask

    task automatic test_cs_select();
        loop_en = 1'b1;
        run_xfer(8'h5A, 1'b0, 1'b0, 1'b0, 2'd2, 2, 1'b0);
        checks++; if (res_cs0 !== 4'b1011) begin errors++; $display("FAIL cs_idx2 got %b want 1011", res_cs0); end
        checks++; if (bus0.din !== 8'h5A) begin errors++; $display("FAIL cs_idx2_din got %h want 5a", bus0.din); end
        run_xfer(8'hC3, 1'b0, 1'b0, 1'b0, 2'd3, 2, 1'b1);
        checks++; if (res_cs0 !== 4'b0111) begin errors++; $display("FAIL cs_idx3 got %b want 0111", res_cs0); end
        checks++; if (res_done != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", res_done); end
        checks++; if (res_busy != 76) begin errors++; $display("FAIL busy_start_len got %0d want 76", res_busy); end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart got busy=%b want 0", bus0.busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [3];
        vec[0] = 8'hA5; vec[1] = 8'h3C; vec[2] = 8'hFF;
        loop_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_xfer(vec[i], 1'b0, 1'b0, 1'b0, 2'd0, (i == 0) ? 2 : 0, 1'b0);
            checks++; if (bus0.din !== vec[i]) begin errors++; $display("FAIL b2b%0d_din got %h want %h", i, bus0.din, vec[i]); end
            checks++; if (res_done != 1) begin errors++; $display("FAIL b2b%0d_done got %0d want 1", i, res_done); end
            if (i > 0) begin
                checks++; if (res_gap < 4) begin errors++; $display("FAIL b2b%0d_cs_high got %0d want >=4", i, res_gap); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, e0, d0;
        loop_en = 1'b1;
        bus0.dout = 8'h96; bus0.cpol = 1'b0; bus0.cpha = 1'b0; bus0.lsb_first = 1'b0; bus0.cs_idx = 2'd0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        e0 = sck_tot; d0 = done_tot;
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        k = 0;
        while ((sck_tot - e0) < 7 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checks++; if (k >= 200) begin errors++; $display("FAIL rst_mid_timeout edges %0d want 7", sck_tot - e0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus0.cs_n !== 4'hF) begin errors++; $display("FAIL rst_mid_cs_n got %b want 1111", bus0.cs_n); end
        checks++; if (bus0.sck !== 1'b0) begin errors++; $display("FAIL rst_mid_sck got %b want 0", bus0.sck); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus0.busy); end
        checks++; if (bus0.din !== 8'h00) begin errors++; $display("FAIL rst_mid_din got %h want 00", bus0.din); end
        @(posedge clk); #1;
        checks++; if (done_tot != d0) begin errors++; $display("FAIL rst_mid_done got %0d pulses want 0", done_tot - d0); end
        rst_n = 1'b1;
        run_xfer(8'h69, 1'b0, 1'b0, 1'b0, 2'd0, 2, 1'b0);
        checks++; if (bus0.din !== 8'h69) begin errors++; $display("FAIL rst_after_din got %h want 69", bus0.din); end
        checks++; if (res_done != 1) begin errors++; $display("FAIL rst_after_done got %0d want 1", res_done); end
    endtask

    task automatic test_clk_div1();
        logic [10:0] vec [2];
        vec[0] = {8'hA5, 1'b0, 1'b0, 1'b0};
        vec[1] = {8'h3C, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            int k, b0, d0, e0;
            bus1.dout = vec[i][10:3]; bus1.cpol = vec[i][2]; bus1.cpha = vec[i][1]; bus1.lsb_first = vec[i][0];
            repeat (3) begin
                @(posedge clk); #1;
            end
            b0 = busy1_tot; d0 = done1_tot; e0 = sck1_tot;
            bus1.start = 1'b1;
            @(posedge clk); #1;
            bus1.start = 1'b0;
            k = 0;
            while (bus1.busy !== 1'b0 && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            checks++; if (k >= 100) begin errors++; $display("FAIL div1_%0d_timeout busy=%b", i, bus1.busy); end
            checks++; if (busy1_tot - b0 != L1) begin errors++; $display("FAIL div1_%0d_busy_len got %0d want %0d", i, busy1_tot - b0, L1); end
            checks++; if (sck1_tot - e0 != 16) begin errors++; $display("FAIL div1_%0d_sck_edges got %0d want 16", i, sck1_tot - e0); end
            checks++; if (bus1.din !== vec[i][10:3]) begin errors++; $display("FAIL div1_%0d_din got %h want %h", i, bus1.din, vec[i][10:3]); end
            checks++; if (done1_tot - d0 != 1) begin errors++; $display("FAIL div1_%0d_done got %0d want 1", i, done1_tot - d0); end
        end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.cpol = 1'b0; bus0.cpha = 1'b0; bus0.lsb_first = 1'b0;
        bus0.cs_idx = 2'd0; bus0.dout = 8'h00;
        bus1.start = 1'b0; bus1.cpol = 1'b0; bus1.cpha = 1'b0; bus1.lsb_first = 1'b0;
        bus1.cs_idx = 1'b0; bus1.dout = 8'h00;
        test_reset();
        test_mode0_loopback();
        test_modes();
        test_lsb_first();
        test_cs_select();
        test_back_to_back();
        test_reset_mid();
        test_clk_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
